// File: rtl/pixel_adjust_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_adjust_stage_if
// Brief    : Valid/ready pixel stream bundle with start-of-frame marker.
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_adjust_stage_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              sof;

  modport master (output valid, output data, output sof, input  ready);
  modport slave  (input  valid, input  data, input  sof, output ready);
endinterface
`default_nettype wire

// File: rtl/pixel_adjust_stage.sv
`default_nettype none
// ============================================================================
// Module   : pixel_adjust_stage
// Brief    : Frame-synchronous brighten/darken of a grey pixel stream with a
//            2-entry (output + skid) buffer and fully registered in_ready.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_adjust_stage #(
  parameter int DATA_W = 8,
  parameter int STEP   = 64
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             bright_n,
  input  wire logic             dark_n,
  pixel_adjust_stage_if.slave   up,
  pixel_adjust_stage_if.master  dn,
  output logic [1:0]            active_mode
);

  localparam logic [1:0]      c_mode_pass   = 2'b00;
  localparam logic [1:0]      c_mode_bright = 2'b01;
  localparam logic [1:0]      c_mode_dark   = 2'b10;
  localparam logic [DATA_W:0] c_step        = (DATA_W+1)'(STEP);

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b10
  } occ_t;

  occ_t              r_state;
  occ_t              w_state_next;
  logic              r_in_ready;
  logic [1:0]        r_bright_sync;
  logic [1:0]        r_dark_sync;
  logic [1:0]        r_active_mode;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sof;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_skid_sof;

  logic              w_in_fire;
  logic              w_out_fire;
  logic [1:0]        w_req_mode;
  logic [1:0]        w_pix_mode;
  logic [DATA_W-1:0] w_adj_data;
  logic              w_load_out_in;
  logic              w_load_out_skid;
  logic              w_load_skid;

  function automatic logic [DATA_W-1:0] adjust(input logic [DATA_W-1:0] pix,
                                               input logic [1:0]        mode);
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    sum  = {1'b0, pix} + c_step;
    diff = {1'b0, pix} - c_step;
    case (mode)
      c_mode_bright: adjust = sum[DATA_W]  ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
      c_mode_dark:   adjust = diff[DATA_W] ? {DATA_W{1'b0}} : diff[DATA_W-1:0];
      default:       adjust = pix;
    endcase
  endfunction

  // Push-buttons are asynchronous to the pixel clock; deasserted level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bright_sync <= 2'b11;
      r_dark_sync   <= 2'b11;
    end else begin
      r_bright_sync <= {r_bright_sync[0], bright_n};
      r_dark_sync   <= {r_dark_sync[0], dark_n};
    end
  end

  always_comb begin
    w_req_mode = c_mode_pass;
    if (!r_bright_sync[1] && r_dark_sync[1]) w_req_mode = c_mode_bright;
    if (r_bright_sync[1] && !r_dark_sync[1]) w_req_mode = c_mode_dark;
  end

  assign w_in_fire  = up.valid && r_in_ready;
  assign w_out_fire = (r_state != S_EMPTY) && dn.ready;
  // A start-of-frame pixel already uses the mode it is about to latch.
  assign w_pix_mode = up.sof ? w_req_mode : r_active_mode;
  assign w_adj_data = adjust(up.data, w_pix_mode);

  always_comb begin
    w_state_next    = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_state_next  = S_ONE;
          w_load_out_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in_fire && !w_out_fire) begin
          w_state_next = S_TWO;
          w_load_skid  = 1'b1;
        end else if (w_in_fire && w_out_fire) begin
          w_load_out_in = 1'b1;
        end else if (w_out_fire) begin
          w_state_next = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_out_fire) begin
          w_state_next    = S_ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_EMPTY;
      r_in_ready    <= 1'b0;
      r_active_mode <= c_mode_pass;
      r_out_data    <= '0;
      r_out_sof     <= 1'b0;
      r_skid_data   <= '0;
      r_skid_sof    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != S_TWO);
      if (w_in_fire && up.sof) begin
        r_active_mode <= w_req_mode;
      end
      if (w_load_out_in) begin
        r_out_data <= w_adj_data;
        r_out_sof  <= up.sof;
      end else if (w_load_out_skid) begin
        r_out_data <= r_skid_data;
        r_out_sof  <= r_skid_sof;
      end
      if (w_load_skid) begin
        r_skid_data <= w_adj_data;
        r_skid_sof  <= up.sof;
      end
    end
  end

  assign up.ready    = r_in_ready;
  assign dn.valid    = (r_state != S_EMPTY);
  assign dn.data     = r_out_data;
  assign dn.sof      = r_out_sof;
  assign active_mode = r_active_mode;

endmodule
`default_nettype wire

// File: tb/tb_pixel_adjust_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_adjust_stage
// Brief    : Directed self-checking bench for pixel_adjust_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_adjust_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bright_n;
  logic       dark_n;
  logic [1:0] active_mode;
  int         n_checks = 0;
  int         n_fail   = 0;

  pixel_adjust_stage_if #(.DATA_W(8)) up_if ();
  pixel_adjust_stage_if #(.DATA_W(8)) dn_if ();

  pixel_adjust_stage #(.DATA_W(8), .STEP(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bright_n    (bright_n),
    .dark_n      (dark_n),
    .up          (up_if),
    .dn          (dn_if),
    .active_mode (active_mode)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_one(input logic [7:0] d, input logic s);
    up_if.valid = 1'b1;
    up_if.data  = d;
    up_if.sof   = s;
    @(posedge clk); #1;
    up_if.valid = 1'b0;
    up_if.sof   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks += 5;
    if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", dn_if.valid); end
    if (dn_if.data !== 8'd0)  begin n_fail++; $display("FAIL rst_out_data got %0d exp 0", dn_if.data); end
    if (dn_if.sof !== 1'b0)   begin n_fail++; $display("FAIL rst_out_sof got %b exp 0", dn_if.sof); end
    if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0", up_if.ready); end
    if (active_mode !== 2'b00) begin n_fail++; $display("FAIL rst_mode got %b exp 00", active_mode); end
    idle(2);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready got %b exp 1", up_if.ready); end
    idle(2);
  endtask

  task automatic test_pass();
    logic [7:0] vec [3];
    vec[0] = 8'd0; vec[1] = 8'd100; vec[2] = 8'd255;
    for (int i = 0; i < 3; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = vec[i];
      up_if.sof   = (i == 0);
      @(posedge clk); #1;
      n_checks += 3;
      if (dn_if.valid !== 1'b1) begin n_fail++; $display("FAIL pass_valid[%0d] got %b exp 1", i, dn_if.valid); end
      if (dn_if.data !== vec[i]) begin n_fail++; $display("FAIL pass_data[%0d] got %0d exp %0d", i, dn_if.data, vec[i]); end
      if (dn_if.sof !== (i == 0)) begin n_fail++; $display("FAIL pass_sof[%0d] got %b exp %b", i, dn_if.sof, (i == 0)); end
    end
    up_if.valid = 1'b0;
    up_if.sof   = 1'b0;
    @(posedge clk); #1;
    n_checks += 2;
    if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL pass_drain got %b exp 0", dn_if.valid); end
    if (active_mode !== 2'b00) begin n_fail++; $display("FAIL pass_mode got %b exp 00", active_mode); end
  endtask

  task automatic test_bright();
    bright_n = 1'b0;
    idle(3);
    drive_one(8'd200, 1'b1);
    n_checks += 2;
    if (dn_if.data !== 8'd255) begin n_fail++; $display("FAIL bright_sat got %0d exp 255", dn_if.data); end
    if (active_mode !== 2'b01) begin n_fail++; $display("FAIL bright_mode got %b exp 01", active_mode); end
    drive_one(8'd10, 1'b0);
    n_checks++;
    if (dn_if.data !== 8'd74) begin n_fail++; $display("FAIL bright_add got %0d exp 74", dn_if.data); end
    bright_n = 1'b1;
    idle(3);
  endtask

  task automatic test_dark();
    dark_n = 1'b0;
    idle(3);
    drive_one(8'd30, 1'b1);
    n_checks += 2;
    if (dn_if.data !== 8'd0) begin n_fail++; $display("FAIL dark_sat got %0d exp 0", dn_if.data); end
    if (active_mode !== 2'b10) begin n_fail++; $display("FAIL dark_mode got %b exp 10", active_mode); end
    drive_one(8'd64, 1'b0);
    n_checks++;
    if (dn_if.data !== 8'd0) begin n_fail++; $display("FAIL dark_exact got %0d exp 0", dn_if.data); end
    bright_n = 1'b0;
    idle(3);
    drive_one(8'd77, 1'b1);
    n_checks += 2;
    if (dn_if.data !== 8'd77) begin n_fail++; $display("FAIL both_pass got %0d exp 77", dn_if.data); end
    if (active_mode !== 2'b00) begin n_fail++; $display("FAIL both_mode got %b exp 00", active_mode); end
    bright_n = 1'b1;
    dark_n   = 1'b1;
    idle(3);
  endtask

  task automatic test_midframe();
    drive_one(8'd40, 1'b1);
    n_checks++;
    if (dn_if.data !== 8'd40) begin n_fail++; $display("FAIL mid_first got %0d exp 40", dn_if.data); end
    bright_n = 1'b0;
    idle(3);
    drive_one(8'd41, 1'b0);
    n_checks += 2;
    if (dn_if.data !== 8'd41) begin n_fail++; $display("FAIL mid_hold got %0d exp 41", dn_if.data); end
    if (active_mode !== 2'b00) begin n_fail++; $display("FAIL mid_mode got %b exp 00", active_mode); end
    drive_one(8'd42, 1'b1);
    n_checks += 2;
    if (dn_if.data !== 8'd106) begin n_fail++; $display("FAIL mid_newsof got %0d exp 106", dn_if.data); end
    if (active_mode !== 2'b01) begin n_fail++; $display("FAIL mid_newmode got %b exp 01", active_mode); end
    drive_one(8'd43, 1'b0);
    n_checks++;
    if (dn_if.data !== 8'd107) begin n_fail++; $display("FAIL mid_next got %0d exp 107", dn_if.data); end
    bright_n = 1'b1;
    idle(3);
  endtask

  task automatic test_backpressure();
    logic [7:0] src [6];
    logic [7:0] held;
    logic       hold_pending;
    logic       fin;
    logic       fout;
    int         wr = 0;
    int         rd = 0;
    for (int i = 0; i < 6; i++) src[i] = 8'(10 + 3 * i);
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = src[0];
    up_if.sof   = 1'b1;
    for (int cyc = 0; cyc < 60 && rd < 6; cyc++) begin
      if (cyc >= 5) dn_if.ready = (cyc % 3 != 0);
      fin  = up_if.valid && up_if.ready;
      fout = dn_if.valid && dn_if.ready;
      if (fout) begin
        n_checks += 2;
        if (dn_if.data !== src[rd]) begin n_fail++; $display("FAIL bp_order[%0d] got %0d exp %0d", rd, dn_if.data, src[rd]); end
        if (dn_if.sof !== (rd == 0)) begin n_fail++; $display("FAIL bp_sof[%0d] got %b exp %b", rd, dn_if.sof, (rd == 0)); end
        rd++;
      end
      if (fin) wr++;
      held         = dn_if.data;
      hold_pending = dn_if.valid && !dn_if.ready;
      @(posedge clk); #1;
      if (hold_pending) begin
        n_checks++;
        if (dn_if.data !== held) begin n_fail++; $display("FAIL bp_stable got %0d exp %0d", dn_if.data, held); end
      end
      up_if.valid = (wr < 6);
      up_if.sof   = (wr == 0);
      if (wr < 6) up_if.data = src[wr];
      if (cyc == 4) begin
        n_checks += 2;
        if (wr != 2) begin n_fail++; $display("FAIL bp_accepts got %0d exp 2", wr); end
        if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b exp 0", up_if.ready); end
      end
    end
    n_checks++;
    if (rd != 6) begin n_fail++; $display("FAIL bp_delivered got %0d exp 6", rd); end
    up_if.valid = 1'b0;
    up_if.sof   = 1'b0;
    dn_if.ready = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_mid();
    bright_n = 1'b0;
    idle(3);
    dn_if.ready = 1'b0;
    drive_one(8'd20, 1'b1);
    drive_one(8'd30, 1'b0);
    n_checks += 3;
    if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL rm_full got %b exp 0", up_if.ready); end
    if (dn_if.data !== 8'd84) begin n_fail++; $display("FAIL rm_head got %0d exp 84", dn_if.data); end
    if (active_mode !== 2'b01) begin n_fail++; $display("FAIL rm_mode got %b exp 01", active_mode); end
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b exp 0", dn_if.valid); end
    if (active_mode !== 2'b00) begin n_fail++; $display("FAIL rm_rstmode got %b exp 00", active_mode); end
    if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL rm_rstready got %b exp 0", up_if.ready); end
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks += 2;
    if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL rm_relready got %b exp 1", up_if.ready); end
    if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL rm_relvalid got %b exp 0", dn_if.valid); end
    dn_if.ready = 1'b1;
    idle(3);
    drive_one(8'd50, 1'b0);
    n_checks += 3;
    if (dn_if.valid !== 1'b1) begin n_fail++; $display("FAIL rm_post_valid got %b exp 1", dn_if.valid); end
    if (dn_if.data !== 8'd50) begin n_fail++; $display("FAIL rm_post_data got %0d exp 50", dn_if.data); end
    if (active_mode !== 2'b00) begin n_fail++; $display("FAIL rm_post_mode got %b exp 00", active_mode); end
    bright_n = 1'b1;
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bright_n    = 1'b1;
    dark_n      = 1'b1;
    up_if.valid = 1'b0;
    up_if.data  = 8'd0;
    up_if.sof   = 1'b0;
    dn_if.ready = 1'b1;
    test_reset();
    test_pass();
    test_bright();
    test_dark();
    test_midframe();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_adjust_stage.md
PIXEL_ADJUST_STAGE -- requirements
Module: pixel_adjust_stage

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter STEP, default 64, brighten/darken offset (unsigned, < 2^DATA_W).
REQ-003 clk  input  1  pixel clock (VGA pixel clock domain).
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 bright_n  input  1  brighten request, active-low, asynchronous (push-button).
REQ-006 dark_n  input  1  darken request, active-low, asynchronous (push-button).
REQ-007 in_valid  input  1  upstream pixel valid.
REQ-008 in_ready  output  1  stage can accept a pixel this cycle.
REQ-009 in_data  input  DATA_W  upstream pixel (grey level).
REQ-010 in_sof  input  1  marks first pixel of a frame; qualified by in_valid.
REQ-011 out_valid  output  1  output pixel valid.
REQ-012 out_ready  input  1  downstream accepts pixel this cycle.
REQ-013 out_data  output  DATA_W  adjusted pixel.
REQ-014 out_sof  output  1  in_sof delayed alongside its pixel.
REQ-015 active_mode  output  2  mode currently applied: 00 pass, 01 brighten, 10 darken.

Function
REQ-016 Transfer occurs on a side when valid and ready are both high at a rising clk edge.
REQ-017 bright_n and dark_n SHALL each pass a 2-flop synchroniser before use.
REQ-018 Requested mode: bright asserted only -> 01; dark asserted only -> 10; both or neither -> 00.
REQ-019 Requested mode SHALL be latched into active_mode only on the cycle an in_sof pixel is accepted; that pixel and all later pixels of the frame use the new mode.
REQ-020 Brighten: out = min(in + STEP, 2^DATA_W-1), computed in DATA_W+1 bits, saturating.
REQ-021 Darken: out = max(in - STEP, 0), saturating at zero.
REQ-022 Pass: out = in unchanged.
REQ-023 Datapath SHALL be a registered output stage plus one skid register (2-entry buffer); occupancy states EMPTY, ONE, TWO.
REQ-024 in_ready SHALL be high in EMPTY and ONE, low in TWO; in_ready SHALL be a register output (no combinational path from out_ready).
REQ-025 Latency: pixel accepted at edge N appears on out_data with out_valid high after edge N when buffer was EMPTY (1 cycle).
REQ-026 EMPTY: accept -> ONE. ONE: accept and no output transfer -> TWO; accept and output transfer -> ONE; output transfer only -> EMPTY. TWO: output transfer -> ONE (skid entry moves to output register).
REQ-027 Pixel order SHALL be preserved; no pixel dropped or duplicated under any valid/ready pattern.
REQ-028 out_data/out_sof SHALL remain stable while out_valid high and out_ready low.
REQ-029 Mode is computed at acceptance; pixels held in the buffer keep the mode they were accepted with.
REQ-030 Simultaneous in_sof acceptance and button change: the synchronised value present at that edge is latched.

Reset
REQ-031 While rst_n low: out_valid 0, out_data 0, out_sof 0, in_ready 0, active_mode 00, occupancy EMPTY, synchronisers cleared to deasserted (1).
REQ-032 First cycle after rst_n release: in_ready 1.
REQ-033 Reset mid-frame discards buffered pixels; active_mode stays 00 until the next accepted in_sof.

Verification
REQ-034 Mode pass, out_ready held 1, stream 0,100,255 with sof on first -> out 0,100,255, 1-cycle latency, out_sof on first only.
REQ-035 bright_n low 3+ cycles, then sof pixel 200 then 10 -> out 255 (saturated), 74; active_mode 01 from the sof acceptance.
REQ-036 dark_n low, sof pixel 30 then 64 -> out 0, 0; bright_n and dark_n both low -> next frame pass-through.
REQ-037 bright_n asserted mid-frame -> remaining pixels of current frame unchanged; brightened from next sof.
REQ-038 out_ready low 5 cycles with in_valid high -> in_ready drops after 2 accepts, out_data stable; release -> all pixels delivered in order, none lost.
REQ-039 rst_n pulsed low with buffer in TWO -> out_valid 0 immediately, active_mode 00, in_ready 1 one cycle after release.
